serial_word_feeder: RTL

//  Upstream stage of the Moore sequence detector. Accepts WIDTH-bit words over a

---
 rtl/serial_word_feeder_if.sv | 24 ++
 rtl/serial_word_feeder.sv | 76 +++++++
 2 files changed

// File: rtl/serial_word_feeder_if.sv
// serial_word_feeder_if: word handshake in, serial bit stream out
//   word_in    parallel word, bit 0 serialized first
//   word_valid word_in is valid
//   word_ready feeder can accept a word this cycle
//   bit_out    serial bit toward the detector
//   bit_valid  bit_out holds a real data bit
//   bit_idx    index of the bit currently on bit_out
//   last_bit   bit_out is the final bit of its word
//   busy       a word is shifting or waiting in the hold buffer
interface serial_word_feeder_if #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
);
   logic [WIDTH-1:0] word_in;
   logic             word_valid;
   logic             word_ready;
   logic             bit_out;
   logic             bit_valid;
   logic [IDX_W-1:0] bit_idx;
   logic             last_bit;
   logic             busy;
   modport master (output word_in, word_valid, input word_ready, bit_out, bit_valid, bit_idx, last_bit, busy);
   modport slave (input word_in, word_valid, output word_ready, bit_out, bit_valid, bit_idx, last_bit, busy);
endinterface

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: serializes WIDTH-bit words LSB-first with a one-word hold buffer
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  serial_word_feeder_if.slave (word handshake in, registered bit stream out)
module serial_word_feeder #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input logic clk,
   input logic rst,
   serial_word_feeder_if.slave bus
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, hold, hold_nxt;
   logic             hold_full, hold_full_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             accept, on_last;
   assign accept = bus.word_valid & ~hold_full;
   assign on_last = (state == SHIFT) && (idx == IDX_W'(WIDTH - 1));
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      hold_nxt = hold;
      hold_full_nxt = hold_full;
      idx_nxt = idx;
      if (state == IDLE) begin
         if (accept) begin
            shreg_nxt = bus.word_in;
            idx_nxt = '0;
            state_nxt = SHIFT;
         end
      end else if (!on_last) begin
         shreg_nxt = shreg >> 1;
         idx_nxt = idx + IDX_W'(1);
         if (accept) begin
            hold_nxt = bus.word_in;
            hold_full_nxt = 1'b1;
         end
      end else if (hold_full) begin
         shreg_nxt = hold;
         idx_nxt = '0;
         hold_full_nxt = 1'b0;
      end else if (accept) begin
         // empty hold: the new word goes straight in so the stream has no gap
         shreg_nxt = bus.word_in;
         idx_nxt = '0;
      end else begin
         // clearing the shift register keeps bit_out at 0 while idle
         shreg_nxt = '0;
         idx_nxt = '0;
         state_nxt = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         hold <= '0;
         hold_full <= 1'b0;
         idx <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         hold <= hold_nxt;
         hold_full <= hold_full_nxt;
         idx <= idx_nxt;
      end
   end
   assign bus.word_ready = ~hold_full;
   assign bus.bit_out = shreg[0];
   assign bus.bit_valid = (state == SHIFT);
   assign bus.bit_idx = idx;
   assign bus.last_bit = on_last;
   assign bus.busy = (state == SHIFT) | hold_full;
endmodule
